// File: rtl/logic_unit_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : logic_unit_arbiter
// Purpose  : One registered 2-input bitwise logic unit shared by NREQ
//            requesters. A round-robin arbiter picks one requester per cycle.
//            The result goes to a single-entry output register with
//            valid/ready backpressure.
// Ports    : clk, rst (async, active-high)
//            req[NREQ]         level request per requester
//            op[3*NREQ]        opcode, requester i in [3i+2:3i]
//            a_in/b_in         operands, requester i in [WIDTH*i +: WIDTH]
//            ack[NREQ]         registered one-cycle grant acknowledge
//            res_valid/res_ready/res_data/res_id  result handshake
// Revision : 1.0  initial release
// ============================================================================
module logic_unit_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [3*NREQ-1:0]     op,
  input  logic [WIDTH*NREQ-1:0] a_in,
  input  logic [WIDTH*NREQ-1:0] b_in,
  output logic [NREQ-1:0]       ack,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [WIDTH-1:0]      res_data,
  output logic [IDW-1:0]        res_id
);

  // One extra bit so ptr + offset can exceed NREQ-1 before the wrap.
  localparam int c_CW = IDW + 1;

  logic [NREQ-1:0]  r_ack;
  logic [IDW-1:0]   r_ptr;
  logic             r_res_valid;
  logic [WIDTH-1:0] r_res_data;
  logic [IDW-1:0]   r_res_id;

  logic [2:0]       w_op_arr [NREQ];
  logic [WIDTH-1:0] w_a_arr  [NREQ];
  logic [WIDTH-1:0] w_b_arr  [NREQ];

  logic             w_free;
  logic [NREQ-1:0]  w_elig;
  logic             w_found;
  logic [IDW-1:0]   w_gnt;
  logic [c_CW-1:0]  w_cand;
  logic [2:0]       w_sel_op;
  logic [WIDTH-1:0] w_sel_a;
  logic [WIDTH-1:0] w_sel_b;
  logic [WIDTH-1:0] w_result;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign w_op_arr[gi] = op[3*gi +: 3];
    assign w_a_arr[gi]  = a_in[WIDTH*gi +: WIDTH];
    assign w_b_arr[gi]  = b_in[WIDTH*gi +: WIDTH];
  end

  assign w_free = !r_res_valid || res_ready;
  // A requester acked this cycle still has its old req visible; masking it
  // keeps a held request from being served twice.
  assign w_elig = req & ~r_ack;

  // Round-robin search: first eligible index at or after ptr, with wrap.
  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_cand = {1'b0, r_ptr} + c_CW'(k);
      if (w_cand >= c_CW'(NREQ)) begin
        w_cand = w_cand - c_CW'(NREQ);
      end
      if (!w_found && w_elig[w_cand[IDW-1:0]]) begin
        w_found = 1'b1;
        w_gnt   = w_cand[IDW-1:0];
      end
    end
  end

  assign w_sel_op = w_op_arr[w_gnt];
  assign w_sel_a  = w_a_arr[w_gnt];
  assign w_sel_b  = w_b_arr[w_gnt];

  always_comb begin
    w_result = '0;
    case (w_sel_op)
      3'd0:    w_result = w_sel_a & w_sel_b;
      3'd1:    w_result = w_sel_a | w_sel_b;
      3'd2:    w_result = ~w_sel_a;
      3'd3:    w_result = ~(w_sel_a & w_sel_b);
      3'd4:    w_result = ~(w_sel_a | w_sel_b);
      3'd5:    w_result = w_sel_a ^ w_sel_b;
      3'd6:    w_result = ~(w_sel_a ^ w_sel_b);
      default: w_result = '0;   // opcode 7 reserved
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ack       <= '0;
      r_ptr       <= '0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_id    <= '0;
    end else if (w_free && w_found) begin
      r_res_data  <= w_result;
      r_res_id    <= w_gnt;
      r_res_valid <= 1'b1;
      r_ack       <= {{(NREQ-1){1'b0}}, 1'b1} << w_gnt;
      r_ptr       <= (w_gnt == IDW'(NREQ-1)) ? '0 : w_gnt + 1'b1;
    end else begin
      r_ack <= '0;
      if (res_ready && r_res_valid) begin
        r_res_valid <= 1'b0;
      end
    end
  end

  assign ack       = r_ack;
  assign res_valid = r_res_valid;
  assign res_data  = r_res_data;
  assign res_id    = r_res_id;

endmodule
`default_nettype wire

// File: doc/logic_unit_arbiter.md
# logic_unit_arbiter

Shares one registered 2-input bitwise logic unit (AND, OR, NOT, NAND, NOR, XOR, XNOR) between NREQ requesters. Each requester presents an opcode and two operands under a level request. A round-robin arbiter grants one requester per cycle. The result is delivered through a single-entry output register with valid/ready backpressure. It is the shared gate-evaluation resource for blocks that need per-word logic operations without instantiating their own gate bank.

## Interface
- NREQ, default 4: number of requesters, 2..8.
- WIDTH, default 8: operand/result width in bits.
- IDW, default $clog2(NREQ): width of the requester ID.

- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  NREQ  per-requester request, level-sensitive.
- op  input  3*NREQ  opcode of requester i in bits [3i+2:3i].
- a_in  input  WIDTH*NREQ  operand A of requester i in bits [WIDTH*i+WIDTH-1:WIDTH*i].
- b_in  input  WIDTH*NREQ  operand B, same packing as a_in.
- ack  output  NREQ  one-cycle grant acknowledge, registered.
- res_valid  output  1  output register holds a result.
- res_ready  input  1  consumer accepts the result this cycle.
- res_data  output  WIDTH  result word.
- res_id  output  IDW  index of the requester that produced res_data.

## Operation
- Opcode map, bitwise on WIDTH bits:
  - 0 = a&b, 1 = a|b, 2 = ~a (b ignored), 3 = ~(a&b).
  - 4 = ~(a|b), 5 = a^b, 6 = ~(a^b), 7 = reserved, result all zeros.
- Slot free: `free = !res_valid || res_ready`.
- Eligible set: `req & ~ack`. A requester whose ack is high this cycle is masked, so a held req is never served twice.
- Round-robin search:
  - Starts at index ptr and ascends with wrap NREQ-1 -> 0.
  - The first eligible index is the winner g.
- Grant occurs in a cycle when free is high and the eligible set is non-empty. At that clock edge:
  - res_data <= f(op[g], a_in[g], b_in[g]).
  - res_id <= g.
  - res_valid <= 1.
  - ack <= one-hot(g).
  - ptr <= (g+1) mod NREQ.
- No grant in a cycle:
  - ack <= 0.
  - ptr holds.
  - If res_ready && res_valid, res_valid <= 0. Otherwise res_valid, res_data and res_id hold.
- Output slot states:
  - EMPTY (res_valid=0) -> FULL on grant.
  - FULL -> FULL on grant with res_ready (back-to-back).
  - FULL -> EMPTY on res_ready without grant.
  - FULL holds while res_ready=0. No grants occur in that state.
- Requester protocol:
  - Operands and op must be stable while req is high until ack is seen.
  - After ack, the requester drops req or presents a new operation, no earlier than the cycle after ack.
- Reset (asynchronous, any time, including mid-stall):
  - ack=0, res_valid=0, res_data=0, res_id=0, ptr=0.
  - A pending result is discarded; un-acked requests are re-arbitrated after reset releases.

## Timing
- Latency: request sampled in cycle N produces ack[g]=1 and res_valid=1 in cycle N+1.
- Throughput:
  - With at least two active requesters and res_ready=1: one result per cycle.
  - A single continuously requesting requester gets one result every 2 cycles, due to the ack mask.
- Backpressure: while res_valid=1 and res_ready=0, no grants and all ack stay 0. The first grant follows the cycle res_ready rises.
- ack is never high for more than one consecutive cycle per requester.
- res_data, res_id change only on a grant edge or on reset.

## Test plan
- **Reset:** assert rst mid-cycle with res_valid=1 -> immediately ack=0, res_valid=0, res_data=0, res_id=0; after release, a req[2] op=5 a=8'hF0 b=8'h3C produces res_data=8'hCC, res_id=2 one cycle later.
- **Opcode sweep:** requester 0, a=8'hA5, b=8'h0F, op 0..7, res_ready=1 -> res_data 8'h05, 8'hAF, 8'h5A, 8'hFA, 8'h50, 8'hAA, 8'h55, 8'h00 on consecutive grants, one every 2 cycles.
- **Round robin:** req=4'b1111 held with operands re-presented after each ack, res_ready=1 -> res_id sequence 0, 1, 2, 3, 0, with one ack per cycle. Then req=4'b1010 from ptr=1 -> 1, 3, 1, 3.
- **Backpressure:** req=4'b0011, res_ready=0 after the first grant -> res_valid=1, res_id=0, res_data frozen, ack=0 for 5 cycles; raise res_ready -> next cycle res_id=1 and ack[1]=1.
- **Wrap and mask:** ptr=3, req=4'b1001 -> grant 3 then 0; a single req[0] held high for 6 cycles -> ack[0] pulses on alternate cycles, 3 results.
